cpu_debug_ocimem_arbiter: RTL and testbench

- Sysclk-domain controller for the CPU's on-chip debug monitor RAM.
- Sequences JTAG-originated OCI memory commands (the take_action_ocimem_*/jdo strobes from the debug slave sysclk block) into single-port RAM accesses.
- Shares that RAM with the CPU's Avalon debug-memory slave port.
- Returns read data and status (MonDReg, monitor_ready, monitor_error) to the debug slave TCK block.

---
 rtl/cpu_debug_ocimem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_cpu_debug_ocimem_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_debug_ocimem_arbiter.sv
// Debug monitor RAM controller. It turns JTAG OCI memory commands into single-port
// RAM accesses and shares the RAM with the CPU's Avalon debug-memory slave.
module cpu_debug_ocimem_arbiter #(
  parameter int unsigned AW    = 8,
  parameter bit          JPRIO = 1'b0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [37:0]   jdo,
  input  logic          take_action_ocimem_a,
  input  logic          take_no_action_ocimem_a,
  input  logic          take_action_ocimem_b,
  input  logic [AW-1:0] avs_address,
  input  logic          avs_read,
  input  logic          avs_write,
  input  logic [31:0]   avs_writedata,
  input  logic [3:0]    avs_byteenable,
  output logic [31:0]   avs_readdata,
  output logic          avs_waitrequest,
  output logic [AW-1:0] ram_addr,
  output logic          ram_wren,
  output logic [3:0]    ram_byteen,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,
  output logic [AW-1:0] MonAReg,
  output logic [31:0]   MonDReg,
  output logic          monitor_ready,
  output logic          monitor_error
);

  typedef enum logic [2:0] {IDLE, J_ACC, J_RD, C_ACC, C_RD} state_e;
  typedef enum logic {GNT_CPU, GNT_JTAG} grant_e;

  state_e        state_q, state_d;
  grant_e        last_q, last_d;
  logic          jpend_q, jpend_d;
  logic          jwr_q, jwr_d;
  logic [31:0]   jwdata_q, jwdata_d;
  logic [AW-1:0] mon_a_q, mon_a_d;
  logic [31:0]   mon_d_q, mon_d_d;
  logic          mon_err_q, mon_err_d;
  logic          cpu_req, cpu_done, any_strobe;
  logic          unused_jdo;

  assign unused_jdo = ^{jdo[37], jdo[35], jdo[2:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      last_q    <= GNT_CPU;
      jpend_q   <= 1'b0;
      jwr_q     <= 1'b0;
      jwdata_q  <= '0;
      mon_a_q   <= '0;
      mon_d_q   <= '0;
      mon_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      jpend_q   <= jpend_d;
      jwr_q     <= jwr_d;
      jwdata_q  <= jwdata_d;
      mon_a_q   <= mon_a_d;
      mon_d_q   <= mon_d_d;
      mon_err_q <= mon_err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    last_d          = last_q;
    jpend_d         = jpend_q;
    jwr_d           = jwr_q;
    jwdata_d        = jwdata_q;
    mon_a_d         = mon_a_q;
    mon_d_d         = mon_d_q;
    mon_err_d       = mon_err_q;
    ram_addr        = '0;
    ram_wren        = 1'b0;
    ram_byteen      = '0;
    ram_wdata       = '0;
    avs_readdata    = '0;
    cpu_done        = 1'b0;
    cpu_req         = avs_read | avs_write;
    any_strobe      = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;

    // A strobe arriving while a command is pending is dropped whole; only the error flag moves.
    if (any_strobe) begin
      if (jpend_q) begin
        mon_err_d = 1'b1;
      end else if (take_action_ocimem_a) begin
        mon_a_d = jdo[17 +: AW];
        if (jdo[36]) mon_err_d = 1'b0;
        if (jdo[34]) begin
          jpend_d = 1'b1;
          jwr_d   = 1'b0;
        end
      end else if (take_no_action_ocimem_a) begin
        jpend_d = 1'b1;
        jwr_d   = 1'b0;
      end else begin
        jpend_d  = 1'b1;
        jwr_d    = 1'b1;
        jwdata_d = jdo[34:3];
      end
    end

    unique case (state_q)
      IDLE: begin
        if (jpend_q && (!cpu_req || JPRIO || last_q == GNT_CPU)) begin
          state_d = J_ACC;
          last_d  = GNT_JTAG;
        end else if (cpu_req) begin
          state_d = C_ACC;
          last_d  = GNT_CPU;
        end
      end
      J_ACC: begin
        ram_addr   = mon_a_q;
        ram_byteen = '1;
        if (jwr_q) begin
          ram_wren  = 1'b1;
          ram_wdata = jwdata_q;
          mon_a_d   = mon_a_q + AW'(1);
          jpend_d   = 1'b0;
          state_d   = IDLE;
        end else begin
          state_d = J_RD;
        end
      end
      J_RD: begin
        mon_d_d = ram_rdata;
        mon_a_d = mon_a_q + AW'(1);
        jpend_d = 1'b0;
        state_d = IDLE;
      end
      C_ACC: begin
        ram_addr   = avs_address;
        ram_byteen = avs_byteenable;
        if (avs_write) begin
          ram_wren  = 1'b1;
          ram_wdata = avs_writedata;
          cpu_done  = 1'b1;
          state_d   = IDLE;
        end else if (avs_read) begin
          state_d = C_RD;
        end else begin
          state_d = IDLE;
        end
      end
      C_RD: begin
        avs_readdata = ram_rdata;
        cpu_done     = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign avs_waitrequest = cpu_req & ~cpu_done;
  assign MonAReg         = mon_a_q;
  assign MonDReg         = mon_d_q;
  assign monitor_ready   = ~jpend_q;
  assign monitor_error   = mon_err_q;

endmodule

// File: tb/tb_cpu_debug_ocimem_arbiter.sv
// Scoreboard bench for cpu_debug_ocimem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_cpu_debug_ocimem_arbiter;
  localparam int unsigned AW = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [7:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_wren;
  logic [3:0]  ram_byteen;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [7:0]  MonAReg;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;

  always #5 clk = ~clk;

  cpu_debug_ocimem_arbiter #(.AW(AW), .JPRIO(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_byteen(ram_byteen),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .MonAReg(MonAReg), .MonDReg(MonDReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  function automatic logic [31:0] pat(input int unsigned i);
    return {8'(i), 8'hC3, 8'(~i), 8'h5A};
  endfunction

  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 256; i++) mem[i] <= pat(i);
    end else if (ram_wren) begin
      for (int unsigned b = 0; b < 4; b++)
        if (ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram_rdata <= mem[ram_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {logic [7:0] addr; logic [31:0] data; logic [3:0] be;} wr_t;
  typedef struct packed {logic is_rd; logic [31:0] data; logic [7:0] next_addr;} jop_t;
  wr_t         wr_q[$];
  logic [31:0] crd_q[$];
  jop_t        j_q[$];
  logic [31:0] ref_mem [256];
  logic [7:0]  exp_addr;
  logic        mon_en = 1'b0;
  logic        prev_ready = 1'b1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (ram_wren) begin
        if (wr_q.size() == 0) check("wr_expected", ram_wren, 1'b0);
        else begin
          wr_t e;
          e = wr_q.pop_front();
          check("wr_addr", ram_addr, e.addr);
          check("wr_data", ram_wdata, e.data);
          check("wr_be", ram_byteen, e.be);
        end
      end
      if (avs_read && !avs_waitrequest) begin
        if (crd_q.size() == 0) check("cpu_rd_expected", avs_read, 1'b0);
        else check("cpu_rdata", avs_readdata, crd_q.pop_front());
      end
      if (monitor_ready && !prev_ready) begin
        if (j_q.size() == 0) check("jtag_done_expected", monitor_ready, 1'b0);
        else begin
          jop_t j;
          j = j_q.pop_front();
          check("jtag_next_addr", MonAReg, j.next_addr);
          if (j.is_rd) check("jtag_rdata", MonDReg, j.data);
        end
      end
    end
    prev_ready <= monitor_ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic rd, input logic clr);
    logic [37:0] v;
    v = '0;
    v[24:17] = addr;
    v[34] = rd;
    v[36] = clr;
    return v;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    logic [37:0] v;
    v = '0;
    v[34:3] = d;
    return v;
  endfunction

  task automatic pulse(input logic a, input logic na, input logic b, input logic [37:0] d);
    take_action_ocimem_a = a;
    take_no_action_ocimem_a = na;
    take_action_ocimem_b = b;
    jdo = d;
    tick();
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    jdo = '0;
  endtask

  task automatic j_load(input logic [7:0] addr, input logic clr);
    exp_addr = addr;
    pulse(1'b1, 1'b0, 1'b0, jdo_a(addr, 1'b0, clr));
  endtask

  task automatic j_read_at(input logic [7:0] addr);
    exp_addr = addr;
    j_q.push_back('{1'b1, ref_mem[addr], addr + 8'd1});
    exp_addr = addr + 8'd1;
    pulse(1'b1, 1'b0, 1'b0, jdo_a(addr, 1'b1, 1'b0));
  endtask

  task automatic j_read_cur();
    j_q.push_back('{1'b1, ref_mem[exp_addr], exp_addr + 8'd1});
    exp_addr = exp_addr + 8'd1;
    pulse(1'b0, 1'b1, 1'b0, '0);
  endtask

  task automatic j_write(input logic [31:0] d);
    wr_q.push_back('{exp_addr, d, 4'hF});
    ref_mem[exp_addr] = d;
    j_q.push_back('{1'b0, 32'h0, exp_addr + 8'd1});
    exp_addr = exp_addr + 8'd1;
    pulse(1'b0, 1'b0, 1'b1, jdo_b(d));
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!monitor_ready && n < 30) begin
      tick();
      n++;
    end
    check("jtag_done", monitor_ready, 1'b1);
  endtask

  task automatic cpu_rd_start(input logic [7:0] addr);
    crd_q.push_back(ref_mem[addr]);
    avs_address = addr;
    avs_read = 1'b1;
  endtask

  task automatic cpu_wr_start(input logic [7:0] addr, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] m;
    m = ref_mem[addr];
    for (int unsigned b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = d[8*b +: 8];
    ref_mem[addr] = m;
    wr_q.push_back('{addr, d, be});
    avs_address = addr;
    avs_writedata = d;
    avs_byteenable = be;
    avs_write = 1'b1;
  endtask

  // Counts sampled cycles up to and including the one where waitrequest is low.
  task automatic cpu_finish(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (avs_waitrequest && lat < 30);
    check("cpu_wait_drop", avs_waitrequest, 1'b0);
    @(posedge clk);
    #1;
    avs_read = 1'b0;
    avs_write = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    avs_address = '0;
    avs_read = 1'b0;
    avs_write = 1'b0;
    avs_writedata = '0;
    avs_byteenable = '0;
    exp_addr = '0;
    for (int unsigned i = 0; i < 256; i++) ref_mem[i] = pat(i);
    repeat (3) @(posedge clk);
    #1;
    check("rst_MonAReg", MonAReg, 8'h00);
    check("rst_MonDReg", MonDReg, 32'h0);
    check("rst_ready", monitor_ready, 1'b1);
    check("rst_error", monitor_error, 1'b0);
    check("rst_waitreq", avs_waitrequest, 1'b0);
    check("rst_wren", ram_wren, 1'b0);
    check("rst_readdata", avs_readdata, 32'h0);
    reset_n = 1'b1;
    tick();
    mon_en = 1'b1;

    // address load only
    j_load(8'h10, 1'b0);
    check("load_addr", MonAReg, 8'h10);
    check("load_ready", monitor_ready, 1'b1);
    tick(); tick();
    check("load_ready_hold", monitor_ready, 1'b1);

    // JTAG write latency
    j_write(32'hDEADBEEF);
    check("jw_ready_low", monitor_ready, 1'b0);
    check("jw_no_early_wr", ram_wren, 1'b0);
    tick();
    check("jw_wren_n2", ram_wren, 1'b1);
    check("jw_addr_n2", ram_addr, 8'h10);
    tick();
    check("jw_ready_n3", monitor_ready, 1'b1);
    check("jw_addr_inc", MonAReg, 8'h11);

    // JTAG read latency
    j_read_at(8'h10);
    tick(); tick();
    check("jr_ready_n3", monitor_ready, 1'b0);
    tick();
    check("jr_ready_n4", monitor_ready, 1'b1);
    check("jr_data_n4", MonDReg, 32'hDEADBEEF);
    check("jr_addr", MonAReg, 8'h11);

    // overrun, then error clear
    j_read_at(8'h20);
    pulse(1'b1, 1'b0, 1'b0, jdo_a(8'h40, 1'b1, 1'b0));
    check("ovr_error", monitor_error, 1'b1);
    check("ovr_addr_kept", MonAReg, 8'h20);
    wait_ready();
    check("ovr_addr_after", MonAReg, 8'h21);
    j_load(8'h21, 1'b1);
    check("clr_error", monitor_error, 1'b0);

    // clear and overrun in one command: overrun wins
    j_read_cur();
    pulse(1'b1, 1'b0, 1'b0, jdo_a(8'h50, 1'b0, 1'b1));
    check("clr_ovr_error", monitor_error, 1'b1);
    check("clr_ovr_addr", MonAReg, 8'h21);
    wait_ready();
    j_load(exp_addr, 1'b1);
    check("clr_error2", monitor_error, 1'b0);

    // address wrap
    j_load(8'hFF, 1'b0);
    j_read_cur();
    wait_ready();
    check("wrap_addr", MonAReg, 8'h00);
    check("wrap_data", MonDReg, pat(255));

    // uncontended CPU accesses (leaves last grant on CPU)
    cpu_wr_start(8'h03, 32'h12345678, 4'b0101);
    cpu_finish(lat);
    check("cpu_wr_latency", lat, 2);
    cpu_rd_start(8'h03);
    cpu_finish(lat);
    check("cpu_rd_latency", lat, 3);

    // conflict with last grant CPU: JTAG first
    j_load(8'h09, 1'b0);
    j_write(32'hCAFEF00D);
    cpu_rd_start(8'h05);
    tick();
    check("c1_jtag_wren", ram_wren, 1'b1);
    check("c1_jtag_addr", ram_addr, 8'h09);
    check("c1_cpu_held", avs_waitrequest, 1'b1);
    cpu_finish(lat);
    wait_ready();

    // JTAG-only access, then conflict with last grant JTAG: CPU first
    j_read_cur();
    wait_ready();
    j_read_cur();
    cpu_wr_start(8'h0C, 32'hA1B2C3D4, 4'hF);
    tick();
    check("c2_cpu_wren", ram_wren, 1'b1);
    check("c2_cpu_addr", ram_addr, 8'h0C);
    check("c2_cpu_waitreq", avs_waitrequest, 1'b0);
    cpu_finish(lat);
    wait_ready();
    check("c2_jtag_addr", MonAReg, exp_addr);

    // reset mid-access drops the pending command
    j_read_cur();
    tick();
    mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    check("mid_rst_ready", monitor_ready, 1'b1);
    check("mid_rst_addr", MonAReg, 8'h00);
    check("mid_rst_wren", ram_wren, 1'b0);
    j_q.delete();
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick();
    check("post_rst_ready", monitor_ready, 1'b1);
    check("post_rst_error", monitor_error, 1'b0);

    check("wr_q_empty", 32'(wr_q.size()), 32'd0);
    check("crd_q_empty", 32'(crd_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
